gf_divider: RTL and testbench

- Sequential dual-mode divider; the inverse-operation companion to the team's dual-mode gf adder, sharing the same gf_option selector and 32-bit operand width.
- gf_option=1: carry-less polynomial division over GF(2), where subtraction is XOR.
- gf_option=0: unsigned integer restoring division.
- Radix-2, one quotient bit per clock, start/done handshake. Sits beside the adder in the gf operations datapath.

---
 rtl/gf_divider.sv | 126 ++++++++++++
 tb/tb_gf_divider.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/gf_divider.sv
// Sequential radix-2 divider: unsigned integer (gf_option=0) or carry-less GF(2)
// polynomial division (gf_option=1), one quotient bit per clock, start/done handshake.
module gf_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             gf_option,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, ZERO} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    db, db_c;
  logic             mode;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] quo, rem, rem_nxt;
  logic [WIDTH:0]   r_ext;
  logic [WIDTH-1:0] r_sh, r_diff;
  logic             q_bit;
  logic             last;
  logic             done_r, dbz_r;

  assign last = (cnt == CW'(WIDTH - 1));

  // Index of the highest set bit of the divisor (degree of b in GF mode).
  always_comb begin
    db_c = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (b[i]) db_c = CW'(i);
    end
  end

  // quo doubles as the dividend shift register: its MSB feeds the partial
  // remainder while new quotient bits enter at the LSB.
  always_comb begin
    r_ext   = {rem, quo[WIDTH-1]};
    r_sh    = {rem[WIDTH-2:0], quo[WIDTH-1]};
    r_diff  = r_sh - b_reg;
    q_bit   = 1'b0;
    rem_nxt = r_sh;
    if (mode) begin
      if (r_sh[db]) begin
        q_bit   = 1'b1;
        rem_nxt = r_sh ^ b_reg;
      end
    end else if (r_ext >= {1'b0, b_reg}) begin
      q_bit   = 1'b1;
      rem_nxt = r_diff;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (b == '0) ? ZERO : RUN;
      RUN:     if (last) state_nxt = IDLE;
      ZERO:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt    <= '0;
      db     <= '0;
      mode   <= 1'b0;
      b_reg  <= '0;
      quo    <= '0;
      rem    <= '0;
      done_r <= 1'b0;
      dbz_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mode  <= gf_option;
            b_reg <= b;
            db    <= db_c;
            cnt   <= '0;
            dbz_r <= (b == '0);
            if (b == '0) begin
              quo <= '1;
              rem <= a;
            end else begin
              quo <= a;
              rem <= '0;
            end
          end
        end
        RUN: begin
          quo <= {quo[WIDTH-2:0], q_bit};
          rem <= rem_nxt;
          cnt <= cnt + 1'b1;
          if (last) done_r <= 1'b1;
        end
        ZERO:    done_r <= 1'b1;
        default: ;
      endcase
    end
  end

  assign busy        = (state != IDLE);
  assign done        = done_r;
  assign quotient    = quo;
  assign remainder   = rem;
  assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_gf_divider.sv
// Scoreboard bench for gf_divider: directed divisions push expected results,
// a negedge monitor checks every done pulse for values and exact cycle.
module tb_gf_divider;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         start = 1'b0;
  logic         gf_option = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  gf_divider #(.WIDTH(W)) dut (
    .clk(clk), .resetn(resetn), .start(start), .gf_option(gf_option),
    .a(a), .b(b), .busy(busy), .done(done), .quotient(quotient),
    .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (resetn && done) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: done=1 with nothing outstanding (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, ".quotient"}, quotient, e.q);
        check({e.name, ".remainder"}, remainder, e.r);
        check({e.name, ".div_by_zero"}, W'(div_by_zero), W'(e.dbz));
        check({e.name, ".done_cycle"}, W'(cyc), W'(e.cyc));
        check({e.name, ".busy_at_done"}, W'(busy), '0);
      end
    end
  end

  // Issues one division; returns at the negedge after the accepting edge E.
  task automatic issue(input string name, input logic mode, input logic [W-1:0] av,
                       input logic [W-1:0] bv, input logic [W-1:0] eq,
                       input logic [W-1:0] er, input logic edbz);
    exp_t e;
    @(negedge clk);
    start = 1'b1; gf_option = mode; a = av; b = bv;
    @(negedge clk);
    start = 1'b0;
    check({name, ".busy_after_start"}, W'(busy), W'(1));
    e.name = name; e.q = eq; e.r = er; e.dbz = edbz;
    e.cyc = cyc + ((bv == '0) ? 1 : W);
    sb.push_back(e);
    // Scramble inputs: they must have no effect while busy.
    gf_option = ~mode; a = ~av; b = 32'h1234_5678;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL timeout: %0d results still outstanding (cycle %0d)", sb.size(), cyc);
      sb.delete();
    end
  endtask

  initial begin
    int e0;
    exp_t e;

    #12;
    check("reset.busy", W'(busy), '0);
    check("reset.done", W'(done), '0);
    check("reset.quotient", quotient, '0);
    check("reset.remainder", remainder, '0);
    check("reset.div_by_zero", W'(div_by_zero), '0);
    @(negedge clk);
    resetn = 1'b1;

    issue("int_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    wait_idle();
    issue("gf_1c_5", 1'b1, 32'h1C, 32'h5, 32'h6, 32'h2, 1'b0);
    wait_idle();
    issue("gf_72_28", 1'b1, 32'd72, 32'd28, 32'h6, 32'h0, 1'b0);
    wait_idle();
    issue("int_28_72", 1'b0, 32'd28, 32'd72, 32'h0, 32'd28, 1'b0);
    wait_idle();
    issue("int_msb_div", 1'b0, 32'hFFFF_FFFF, 32'h8000_0001, 32'h1, 32'h7FFF_FFFE, 1'b0);
    wait_idle();
    issue("int_div1", 1'b0, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFF, 32'h0, 1'b0);
    wait_idle();
    issue("gf_div1", 1'b1, 32'h1234_5678, 32'h1, 32'h1234_5678, 32'h0, 1'b0);
    wait_idle();
    issue("gf_x31_xp1", 1'b1, 32'h8000_0000, 32'h3, 32'h7FFF_FFFF, 32'h1, 1'b0);
    wait_idle();
    issue("gf_lowdeg", 1'b1, 32'h3, 32'h7, 32'h0, 32'h3, 1'b0);
    wait_idle();
    issue("int_deadbeef_16", 1'b0, 32'hDEAD_BEEF, 32'h10, 32'h0DEA_DBEE, 32'hF, 1'b0);
    wait_idle();

    issue("int_div0", 1'b0, 32'd25, 32'd0, 32'hFFFF_FFFF, 32'd25, 1'b1);
    wait_idle();
    @(negedge clk);
    check("div0_held", W'(div_by_zero), W'(1));
    issue("gf_div0", 1'b1, 32'd25, 32'd0, 32'hFFFF_FFFF, 32'd25, 1'b1);
    wait_idle();
    issue("clear_div0", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    wait_idle();
    @(negedge clk);
    check("result_held.quotient", quotient, 32'd14);

    // Start pulse at E+5 while busy must be ignored.
    issue("ignore_2nd", 1'b0, 32'd1000, 32'd9, 32'd111, 32'd1, 1'b0);
    e0 = cyc;
    while (cyc < e0 + 4) @(negedge clk);
    start = 1'b1; gf_option = 1'b1; a = 32'd77; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Start held high through the done cycle: second division accepted at E+33.
    @(negedge clk);
    start = 1'b1; gf_option = 1'b0; a = 32'd500; b = 32'd7;
    @(negedge clk);
    e0 = cyc;
    e.name = "b2b_first"; e.q = 32'd71; e.r = 32'd3; e.dbz = 1'b0; e.cyc = e0 + W;
    sb.push_back(e);
    e.name = "b2b_second"; e.q = 32'h6; e.r = 32'h2; e.dbz = 1'b0; e.cyc = e0 + W + 1 + W;
    sb.push_back(e);
    gf_option = 1'b1; a = 32'h1C; b = 32'h5;
    while (cyc < e0 + W + 1) @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Asynchronous reset mid-division aborts with no done pulse.
    issue("aborted", 1'b0, 32'hFFFF_0000, 32'd3, 32'h0, 32'h0, 1'b0);
    e0 = cyc;
    while (cyc < e0 + 9) @(negedge clk);
    @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    sb.delete();
    check("abort.busy", W'(busy), '0);
    check("abort.done", W'(done), '0);
    check("abort.quotient", quotient, '0);
    check("abort.remainder", remainder, '0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (40) @(negedge clk);
    issue("after_reset", 1'b1, 32'd72, 32'd28, 32'h6, 32'h0, 1'b0);
    wait_idle();

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
